// File: rtl/main_memory_ctrl.sv
// Line-oriented memory controller: one outstanding request, fixed response latency,
// per-byte write masking, out-of-range detection and completed-access counters.
module main_memory_ctrl #(
   parameter int BLOCK_SIZE = 4,
   parameter int NUM_BLOCKS = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int LATENCY    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wmask,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err,
   output logic [31:0]             rd_count,
   output logic [31:0]             wr_count
);

   localparam int BPL        = DATA_WIDTH / (8 * BLOCK_SIZE);
   localparam int BPL_NZ     = (BPL == 0) ? 1 : BPL;
   localparam int LINE_BYTES = BPL_NZ * BLOCK_SIZE;
   localparam int MEM_BYTES  = NUM_BLOCKS * BLOCK_SIZE;
   localparam int IDX_W      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   if ((DATA_WIDTH % (8 * BLOCK_SIZE)) != 0 || BPL == 0) begin : g_err_data_width
      $error("main_memory_ctrl: DATA_WIDTH must be a non-zero multiple of 8*BLOCK_SIZE");
   end
   if ((NUM_BLOCKS % BPL_NZ) != 0) begin : g_err_num_blocks
      $error("main_memory_ctrl: NUM_BLOCKS must be a multiple of blocks per line");
   end
   if (LATENCY < 1) begin : g_err_latency
      $error("main_memory_ctrl: LATENCY must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wmask_q, wmask_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
   logic                    resp_err_q, resp_err_d;
   logic [31:0]             rd_count_q, rd_count_d;
   logic [31:0]             wr_count_q, wr_count_d;
   logic [7:0]              mem_q [MEM_BYTES];
   logic [7:0]              mem_d [MEM_BYTES];

   logic                    in_range;
   logic [ADDR_WIDTH-1:0]   line_base;
   logic [IDX_W-1:0]        base_idx;

   // Compare one bit wider than the address so a memory as large as the address space cannot wrap.
   assign in_range  = ({1'b0, addr_q} < (ADDR_WIDTH+1)'(MEM_BYTES));
   assign line_base = addr_q - (addr_q % ADDR_WIDTH'(LINE_BYTES));
   assign base_idx  = line_base[IDX_W-1:0];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      rd_count_d   = rd_count_q;
      wr_count_d   = wr_count_q;
      mem_d        = mem_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wmask_d = req_wmask;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
               resp_err_d   = !in_range;
               if (in_range) begin
                  for (int unsigned i = 0; i < LINE_BYTES; i++) begin
                     if (write_q) begin
                        if (wmask_q[i]) mem_d[base_idx + IDX_W'(i)] = wdata_q[8*i +: 8];
                     end else begin
                        resp_rdata_d[8*i +: 8] = mem_q[base_idx + IDX_W'(i)];
                     end
                  end
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               if (!resp_err_q) begin
                  if (write_q) wr_count_d = wr_count_q + 32'd1;
                  else         rd_count_d = rd_count_q + 32'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         rd_count_q   <= '0;
         wr_count_q   <= '0;
         for (int unsigned i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         rd_count_q   <= rd_count_d;
         wr_count_q   <= wr_count_d;
         for (int unsigned i = 0; i < MEM_BYTES; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign req_ready  = (state_q == IDLE) && !rst;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign rd_count   = rd_count_q;
   assign wr_count   = wr_count_q;

endmodule

// File: doc/main_memory_ctrl.md
MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

Interface
REQ-001 The block SHALL have the parameter BLOCK_SIZE, default 4: bytes per memory block.
REQ-002 The block SHALL have the parameter NUM_BLOCKS, default 8: number of blocks in memory.
REQ-003 The block SHALL have the parameter ADDR_WIDTH, default 32: byte-address width.
REQ-004 The block SHALL have the parameter DATA_WIDTH, default 128: line width in bits (BPL = DATA_WIDTH/(8*BLOCK_SIZE) blocks per line).
REQ-005 The block SHALL have the parameter LATENCY, default 4: cycles from request acceptance to response, minimum 1.
REQ-006 The block SHALL have the port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have the port req_valid, input, 1 bit: a request is present.
REQ-009 The block SHALL have the port req_ready, output, 1 bit: the block can accept a request.
REQ-010 The block SHALL have the port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-011 The block SHALL have the port req_addr, input, ADDR_WIDTH bits: byte address.
REQ-012 The block SHALL have the port req_wdata, input, DATA_WIDTH bits: write line.
REQ-013 The block SHALL have the port req_wmask, input, DATA_WIDTH/8 bits: per-byte write enable; bit i covers wdata[8i+7:8i].
REQ-014 The block SHALL have the port resp_valid, output, 1 bit: a response is present.
REQ-015 The block SHALL have the port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-016 The block SHALL have the port resp_rdata, output, DATA_WIDTH bits: read line.
REQ-017 The block SHALL have the port resp_err, output, 1 bit: out-of-range access.
REQ-018 The block SHALL have the port rd_count, output, 32 bits: number of completed reads.
REQ-019 The block SHALL have the port wr_count, output, 32 bits: number of completed writes.

Function
REQ-020 Storage SHALL be NUM_BLOCKS*BLOCK_SIZE bytes, organised as NUM_BLOCKS/BPL lines; parameters violating DATA_WIDTH%(8*BLOCK_SIZE)==0, NUM_BLOCKS%BPL==0 or LATENCY>=1 SHALL cause an elaboration error.
REQ-021 Line index SHALL be req_addr divided by (BPL*BLOCK_SIZE); low offset bits SHALL be ignored (line-aligned access).
REQ-022 An address >= NUM_BLOCKS*BLOCK_SIZE SHALL be out of range; such an access SHALL NOT modify memory, SHALL return resp_err=1 and resp_rdata=0, and SHALL NOT wrap.
REQ-023 The FSM SHALL have the states IDLE, BUSY and RESP, with one outstanding request maximum.
REQ-024 In IDLE, req_ready=1; req_valid&req_ready SHALL latch write, address, wdata and wmask, load the countdown with LATENCY-1, and go to BUSY (LATENCY=1 goes straight to RESP next cycle).
REQ-025 In BUSY, the counter SHALL decrement each cycle; at 0 it SHALL go to RESP; req_ready=0.
REQ-026 On entry to RESP: a write SHALL update only the masked bytes of the line; a read SHALL register the line into resp_rdata; resp_valid SHALL be 1.
REQ-027 resp_valid is asserted exactly LATENCY cycles after the acceptance edge.
REQ-028 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_valid&resp_ready, then return to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-029 Write responses SHALL carry resp_rdata=0.
REQ-030 rd_count/wr_count SHALL increment by 1 on each response handshake of an in-range read/write, SHALL NOT count errored accesses, and SHALL wrap at 2^32.
REQ-031 Request inputs outside IDLE SHALL be ignored.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, clear the countdown, zero every memory byte and set req_ready=0 during reset and req_ready=1 in the first cycle after.
REQ-033 rst=1 at an edge SHALL set resp_valid=0, resp_rdata=0, resp_err=0, rd_count=0 and wr_count=0.
REQ-034 rst asserted mid-BUSY or mid-RESP SHALL discard the pending access; a pending write SHALL NOT reach memory.

Verification
REQ-035 Scenario -- write then read: write addr 0x10, wdata 0x0123...CDEF, mask all 1s, then read addr 0x10 -> resp_rdata = written line, both responses 4 cycles after acceptance, wr_count=1, rd_count=1.
REQ-036 Scenario -- byte mask: line 0 holds 0; write 0xFF..FF with mask 0x0001 -> read returns 0x00..00FF.
REQ-037 Scenario -- out of range: read addr 0x20 (default params) -> resp_err=1, rdata=0, counters unchanged; write 0x20 then read 0x00 -> line 0 unchanged.
REQ-038 Scenario -- backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0, no second acceptance until the cycle after the handshake.
REQ-039 Scenario -- reset mid-op: write accepted, rst at BUSY cycle 2 -> after reset a read returns 0, counters 0.
REQ-040 Scenario -- LATENCY=1 and offset: request at addr 0x13 -> response 1 cycle after acceptance, accesses line 1.
